uart_rx: RTL

- UART receiver; the receive-side counterpart of the team's UART transmitter and its bit timer.
- Receives async serial frames on rx_i: 1 start bit, DATA_BITS data bits LSB first, optional parity bit, 1 stop bit.
- Runs its own internal bit-period counter with mid-bit sampling.
- Delivers each byte to the core with a one-cycle valid strobe and per-frame error flags.

---
 rtl/uart_rx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver that pairs with the team's UART transmitter. It receives
// asynchronous frames made of one start bit, DATA_BITS data bits sent LSB
// first, an optional parity bit and one stop bit. An internal bit-period
// counter places each sample in the middle of its bit.
//
// Ports
//    clk          system clock
//    reset        asynchronous, active-low reset
//    rx_i         serial line; idles high; asynchronous to clk
//    data_o       last good data word; held until the next good frame
//    rx_valid_o   one-cycle pulse when data_o has just been updated
//    parity_err_o one-cycle pulse alongside rx_valid_o on a parity mismatch
//    frame_err_o  one-cycle pulse when the stop bit is sampled low
//    busy_o       high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int BIT_TIMING = 5208,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 rx_valid_o,
   output logic                 parity_err_o,
   output logic                 frame_err_o,
   output logic                 busy_o
);

   localparam int CW = $clog2(BIT_TIMING);
   localparam int IW = $clog2(DATA_BITS);

   localparam logic [CW-1:0] HALF_LAST  = CW'(BIT_TIMING / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_TIMING - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_BITS - 1);
   localparam logic          USE_PARITY = (PARITY_EN != 0);
   localparam logic          ODD_PARITY = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [CW-1:0]        cnt;
   logic                 cnt_clear;
   logic                 bit_tick;
   logic                 half_tick;
   logic [IW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 perr;
   logic                 rx_meta;
   logic                 rx_s;

   // The serial line is unrelated to clk, so it goes through two flops before
   // anything looks at it. Both flops reset to the idle (high) level so that
   // reset release cannot look like a start edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_s    <= rx_meta;
      end
   end

   assign bit_tick  = (cnt == BIT_LAST);
   assign half_tick = (cnt == HALF_LAST);

   // State register for the frame sequencer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. START samples half a bit in, which confirms the start
   // bit and lines every later sample up with the middle of its bit. A high
   // line at that point means the falling edge was only a glitch. BREAK holds
   // off a new frame until the line has gone back high, so a line held low
   // reports one framing error and not a stream of them. The counter restarts
   // on every state change and also between data bits, because DATA is one
   // state that spans several bit periods.
   always_comb begin
      state_next = state;
      cnt_clear  = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) state_next = START;
         end
         START: begin
            if (half_tick) state_next = rx_s ? IDLE : DATA;
         end
         DATA: begin
            if (bit_tick && bit_idx == IDX_LAST)
               state_next = USE_PARITY ? PARITY : STOP;
         end
         PARITY: begin
            if (bit_tick) state_next = STOP;
         end
         STOP: begin
            if (bit_tick) state_next = rx_s ? IDLE : BREAK;
         end
         BREAK: begin
            if (rx_s) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (state_next != state || (state == DATA && bit_tick))
         cnt_clear = 1'b1;
   end

   // Bit-period counter. It holds at its top value rather than wrapping, so a
   // state that waits on the line (IDLE, BREAK) never produces a spurious tick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (cnt_clear) begin
         cnt <= '0;
      end else if (cnt != BIT_LAST) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Datapath: gather the data bits, check parity, and on the stop sample
   // either deliver the word or flag a framing error. The three outputs are
   // pulses, so they fall back to zero on every cycle that does not set them.
   // A frame with a bad stop bit leaves data_o alone.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_idx      <= '0;
         shift_reg    <= '0;
         perr         <= 1'b0;
         data_o       <= '0;
         rx_valid_o   <= 1'b0;
         parity_err_o <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         rx_valid_o   <= 1'b0;
         parity_err_o <= 1'b0;
         frame_err_o  <= 1'b0;
         if (state == DATA) begin
            if (bit_tick) begin
               shift_reg[bit_idx] <= rx_s;
               bit_idx            <= bit_idx + IW'(1);
            end
         end else begin
            bit_idx <= '0;
         end
         if (state == PARITY && bit_tick)
            perr <= ((^shift_reg) ^ rx_s) != ODD_PARITY;
         if (state == STOP && bit_tick) begin
            if (rx_s) begin
               data_o       <= shift_reg;
               rx_valid_o   <= 1'b1;
               parity_err_o <= perr & USE_PARITY;
            end else begin
               frame_err_o <= 1'b1;
            end
         end
      end
   end

   assign busy_o = (state != IDLE);

endmodule
